// File: rtl/fifo_pkg.sv
// Shared helpers for the asynchronous FIFO pointer logic.
package fifo_pkg;

    // Smallest synchroniser depth that still gives adequate MTBF.
    localparam int unsigned MIN_SYNC_STAGES = 2;

    // Widest pointer the helpers below handle.
    localparam int unsigned MAX_PTR_W = 32;

    // Gray to binary over the low 'width' bits: bit i = XOR of Gray bits width-1..i.
    function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] gray,
                                                      input int unsigned width);
        logic [MAX_PTR_W-1:0] bin;
        bin = '0;
        for (int i = MAX_PTR_W - 1; i >= 0; i--) begin
            if (i < int'(width)) begin
                bin[i] = gray[i] ^ ((i + 1 < int'(width)) ? bin[i+1] : 1'b0);
            end
        end
        return bin;
    endfunction

    // Binary to Gray over the low 'width' bits.
    function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] bin,
                                                      input int unsigned width);
        logic [MAX_PTR_W-1:0] mask;
        mask = (width >= MAX_PTR_W) ? '1 : ((MAX_PTR_W'(1) << width) - MAX_PTR_W'(1));
        return (bin ^ (bin >> 1)) & mask;
    endfunction

    // Number of set bits among the low 'width' bits.
    function automatic int unsigned popcount(input logic [MAX_PTR_W-1:0] vec,
                                             input int unsigned width);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < int'(MAX_PTR_W); i++) begin
            if (i < int'(width) && vec[i]) begin
                cnt++;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Plain multi-flop synchroniser with synchronous active-low reset.
module sync_ff_chain #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift the asynchronous input through the flop chain; no logic between stages.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/sync_r2w_status.sv
// Read-pointer synchroniser and write-side fill/flag/error generator.
module sync_r2w_status
    import fifo_pkg::*;
#(
    parameter int unsigned ADRRSIZE    = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AFULL_LVL   = (2 ** ADRRSIZE) - 2
) (
    input  logic              wclk,
    input  logic              wrst_n,
    input  logic [ADRRSIZE:0] rptr_gray,
    input  logic [ADRRSIZE:0] wptr_bin,
    input  logic              err_clr,
    output logic [ADRRSIZE:0] wq_rptr_gray,
    output logic [ADRRSIZE:0] wq_rptr_bin,
    output logic [ADRRSIZE:0] wfill,
    output logic              wfull,
    output logic              walmost_full,
    output logic              gray_err,
    output logic              ovf_err
);

    localparam int unsigned DEPTH = 2 ** ADRRSIZE;
    localparam int unsigned PW    = ADRRSIZE + 1;

    localparam logic [ADRRSIZE:0] DepthP = PW'(DEPTH);
    localparam logic [ADRRSIZE:0] AfullP = PW'(AFULL_LVL);

    if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > 4) begin : g_bad_sync
        $error("sync_r2w_status: SYNC_STAGES must be in 2..4");
    end
    if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_afull
        $error("sync_r2w_status: AFULL_LVL must be in 1..DEPTH");
    end

    logic [ADRRSIZE:0] sync_gray;
    logic [ADRRSIZE:0] rbin_q, rbin_d;
    logic [ADRRSIZE:0] prev_gray_q;
    logic [ADRRSIZE:0] diff;
    logic [ADRRSIZE:0] fill_q;
    logic              full_q, afull_q;
    logic              gray_err_q, gray_err_d;
    logic              ovf_err_q, ovf_err_d;
    logic              gray_bad;

    sync_ff_chain #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .d      (rptr_gray),
        .q      (sync_gray)
    );

    // Conversion, fill difference and sticky-error next state.
    always_comb begin
        rbin_d   = PW'(gray2bin(MAX_PTR_W'(sync_gray), PW));
        // Modular subtraction handles pointer wrap naturally.
        diff     = wptr_bin - rbin_q;
        gray_bad = popcount(MAX_PTR_W'(sync_gray ^ prev_gray_q), PW) > 1;
        // Set takes priority over clear.
        gray_err_d = gray_bad | (gray_err_q & ~err_clr);
        ovf_err_d  = (fill_q > DepthP) | (ovf_err_q & ~err_clr);
    end

    // Status registers; full/almost-full come from the same diff as the fill level.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            rbin_q      <= '0;
            prev_gray_q <= '0;
            fill_q      <= '0;
            full_q      <= 1'b0;
            afull_q     <= 1'b0;
            gray_err_q  <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            rbin_q      <= rbin_d;
            prev_gray_q <= sync_gray;
            fill_q      <= diff;
            full_q      <= (diff >= DepthP);
            afull_q     <= (diff >= AfullP);
            gray_err_q  <= gray_err_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

    assign wq_rptr_gray = sync_gray;
    assign wq_rptr_bin  = rbin_q;
    assign wfill        = fill_q;
    assign wfull        = full_q;
    assign walmost_full = afull_q;
    assign gray_err     = gray_err_q;
    assign ovf_err      = ovf_err_q;

endmodule

// File: tb/tb_sync_r2w_status.sv
// Directed bench for sync_r2w_status with a cycle-indexed reference model.
module tb_sync_r2w_status;

    localparam int N     = 512;
    localparam int SYNC  = 2;
    localparam int DEPTH = 8;
    localparam int AFULL = 6;

    logic       wclk = 1'b0;
    logic       wrst_n;
    logic [3:0] rptr_gray;
    logic [3:0] wptr_bin;
    logic       err_clr;
    logic [3:0] wq_rptr_gray;
    logic [3:0] wq_rptr_bin;
    logic [3:0] wfill;
    logic       wfull;
    logic       walmost_full;
    logic       gray_err;
    logic       ovf_err;

    int tests  = 0;
    int fails  = 0;
    int k      = 0;

    // Inputs seen at each rising edge and expected outputs after that edge.
    logic [3:0] r_a [N];
    logic [3:0] w_a [N];
    bit         rst_a [N];
    bit         clr_a [N];
    logic [3:0] eg [N];
    logic [3:0] eb [N];
    logic [3:0] ef [N];
    bit         eff [N];
    bit         eaf [N];
    bit         ege [N];
    bit         eov [N];

    sync_r2w_status #(
        .ADRRSIZE    (3),
        .SYNC_STAGES (SYNC),
        .AFULL_LVL   (AFULL)
    ) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .rptr_gray    (rptr_gray),
        .wptr_bin     (wptr_bin),
        .err_clr      (err_clr),
        .wq_rptr_gray (wq_rptr_gray),
        .wq_rptr_bin  (wq_rptr_bin),
        .wfill        (wfill),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .gray_err     (gray_err),
        .ovf_err      (ovf_err)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, k);
        end
    endtask

    // Inverse Gray by search: the binary value whose Gray encoding matches.
    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        g2b = '0;
        for (int v = 0; v < 16; v++) begin
            b = 4'(v);
            if ((b ^ (b >> 1)) == g) g2b = b;
        end
    endfunction

    // Model: the sync output after edge k is the input sampled SYNC-1 edges earlier,
    // unless a reset edge intervened; everything else is one register behind.
    always @(posedge wclk) begin
        bit         clean;
        logic [3:0] pg, pg2, pb, pf;
        bit         pge, pov;
        if (k < N) begin
            r_a[k]   = rptr_gray;
            w_a[k]   = wptr_bin;
            rst_a[k] = !wrst_n;
            clr_a[k] = err_clr;
            pg  = (k >= 1) ? eg[k-1] : 4'd0;
            pg2 = (k >= 2 && !rst_a[k-1]) ? eg[k-2] : 4'd0;
            pb  = (k >= 1) ? eb[k-1] : 4'd0;
            pf  = (k >= 1) ? ef[k-1] : 4'd0;
            pge = (k >= 1) ? ege[k-1] : 1'b0;
            pov = (k >= 1) ? eov[k-1] : 1'b0;
            if (rst_a[k]) begin
                eg[k] = 0; eb[k] = 0; ef[k] = 0;
                eff[k] = 0; eaf[k] = 0; ege[k] = 0; eov[k] = 0;
            end else begin
                clean = (k >= SYNC - 1);
                for (int j = 0; j < SYNC; j++) begin
                    if (k - j >= 0 && rst_a[k-j]) clean = 0;
                end
                eg[k]  = clean ? r_a[k-SYNC+1] : 4'd0;
                eb[k]  = g2b(pg);
                ef[k]  = w_a[k] - pb;
                eff[k] = (int'(ef[k]) >= DEPTH);
                eaf[k] = (int'(ef[k]) >= AFULL);
                ege[k] = ($countones(pg ^ pg2) > 1) || (pge && !clr_a[k]);
                eov[k] = (int'(pf) > DEPTH) || (pov && !clr_a[k]);
            end
            #1;
            chk("wq_rptr_gray", wq_rptr_gray, eg[k]);
            chk("wq_rptr_bin",  wq_rptr_bin,  eb[k]);
            chk("wfill",        wfill,        ef[k]);
            chk("wfull",        wfull,        eff[k]);
            chk("walmost_full", walmost_full, eaf[k]);
            chk("gray_err",     gray_err,     ege[k]);
            chk("ovf_err",      ovf_err,      eov[k]);
        end
        k++;
    end

    // Advance n edges and settle past the compare process.
    task automatic step(input int n);
        repeat (n) @(posedge wclk);
        #2;
    endtask

    initial begin
        wrst_n = 0; rptr_gray = 4'b0110; wptr_bin = 4'd5; err_clr = 0;
        #2;
        // Reset holds everything at zero.
        step(3);
        chk("lit rst wq_gray", wq_rptr_gray, 0);
        chk("lit rst wfill", wfill, 0);
        chk("lit rst gray_err", gray_err, 0);
        wrst_n = 1;
        step(2);
        chk("lit rel wq_gray", wq_rptr_gray, 4'b0110);

        // Clean restart with both pointers at 0/1.
        wrst_n = 0; rptr_gray = 0; wptr_bin = 1;
        step(1);
        wrst_n = 1;
        step(4);
        chk("lit idle wfill", wfill, 1);

        // Latency of a single Gray step.
        rptr_gray = 4'b0001;
        step(1);
        chk("lit lat wq_gray t+1", wq_rptr_gray, 0);
        step(1);
        chk("lit lat wq_gray", wq_rptr_gray, 1);
        step(1);
        chk("lit lat wq_bin", wq_rptr_bin, 1);
        chk("lit lat wfill old", wfill, 1);
        step(1);
        chk("lit lat wfill", wfill, 0);

        // Flags and overflow.
        rptr_gray = 0; wptr_bin = 6;
        step(5);
        chk("lit fl wfill6", wfill, 6);
        chk("lit fl afull", walmost_full, 1);
        chk("lit fl full0", wfull, 0);
        wptr_bin = 8;
        step(1);
        chk("lit fl wfill8", wfill, 8);
        chk("lit fl full1", wfull, 1);
        wptr_bin = 9;
        step(1);
        chk("lit ovf wfill9", wfill, 9);
        chk("lit ovf early", ovf_err, 0);
        step(1);
        chk("lit ovf set", ovf_err, 1);
        wptr_bin = 8;
        step(3);
        chk("lit ovf sticky", ovf_err, 1);
        err_clr = 1;
        step(1);
        err_clr = 0;
        chk("lit ovf clr", ovf_err, 0);

        // Walk a legal Gray sequence up to binary 14, then wrap the writer to 2.
        for (int b = 1; b <= 14; b++) begin
            rptr_gray = 4'(b ^ (b >> 1));
            wptr_bin  = 4'(b + 2);
            step(1);
        end
        wptr_bin = 2;
        step(5);
        chk("lit wrap wq_bin", wq_rptr_bin, 14);
        chk("lit wrap wfill", wfill, 4);
        chk("lit wrap full", wfull, 0);
        chk("lit wrap afull", walmost_full, 0);
        chk("lit wrap gerr", gray_err, 0);

        // Two-bit Gray jump 1001 -> 1010.
        rptr_gray = 4'b1010;
        step(2);
        chk("lit gerr early", gray_err, 0);
        step(1);
        chk("lit gerr set", gray_err, 1);
        step(2);
        chk("lit gerr sticky", gray_err, 1);
        err_clr = 1;
        step(1);
        err_clr = 0;
        chk("lit gerr clr", gray_err, 0);
        // New jump 1010 -> 1111 with clear on the setting edge: set wins.
        rptr_gray = 4'b1111;
        step(2);
        err_clr = 1;
        step(1);
        err_clr = 0;
        chk("lit gerr set wins", gray_err, 1);

        // Mid-operation reset while full and in error.
        step(3);
        chk("lit mid full", wfull, 1);
        chk("lit mid gerr", gray_err, 1);
        wrst_n = 0;
        step(1);
        wrst_n = 1;
        chk("lit mid wq_gray", wq_rptr_gray, 0);
        chk("lit mid wfill", wfill, 0);
        chk("lit mid full0", wfull, 0);
        chk("lit mid gerr0", gray_err, 0);
        chk("lit mid ovf0", ovf_err, 0);
        step(2);
        chk("lit rec wq_gray", wq_rptr_gray, 4'b1111);
        step(1);
        chk("lit rec wq_bin", wq_rptr_bin, 10);
        step(1);
        chk("lit rec wfill", wfill, 8);
        step(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sync_r2w_status.md
# sync_r2w_status

Parametrised read-pointer synchroniser and write-side status generator for the asynchronous FIFO. It carries the Gray-coded read pointer into the write clock domain through a configurable-depth flop chain and converts it to binary. It then derives fill level, full and almost-full flags against the local write pointer. It also checks Gray-code integrity and fill overflow, and reports both as sticky error flags for the write-side controller and debug registers.

## Interface
Parameters:
- ADRRSIZE, 3, address bits; FIFO depth DEPTH = 2**ADRRSIZE; pointers are ADRRSIZE+1 bits (MSB = wrap bit)
- SYNC_STAGES, 2, synchroniser flop count, legal range 2..4
- AFULL_LVL, DEPTH-2, almost-full threshold, legal range 1..DEPTH

Ports:
- wclk  in  1  write-domain clock
- wrst_n  in  1  reset, synchronous, active-low
- rptr_gray  in  ADRRSIZE+1  read pointer, Gray code, from the read domain (asynchronous)
- wptr_bin  in  ADRRSIZE+1  local write pointer, binary, wclk domain
- err_clr  in  1  clears the sticky error flags
- wq_rptr_gray  out  ADRRSIZE+1  synchronised read pointer, Gray
- wq_rptr_bin  out  ADRRSIZE+1  synchronised read pointer, binary
- wfill  out  ADRRSIZE+1  entries in use, 0..DEPTH
- wfull  out  1  wfill >= DEPTH
- walmost_full  out  1  wfill >= AFULL_LVL
- gray_err  out  1  sticky; two consecutive synchronised samples differed in more than 1 bit
- ovf_err  out  1  sticky; computed fill exceeded DEPTH

## Operation
- Reset: all flops clear on the wclk edge where wrst_n=0, including mid-operation. All outputs read 0 on the following cycle.
- Sync chain: stage 0 samples rptr_gray. Each later stage samples the previous one. The final stage drives wq_rptr_gray. There is no other logic between stages.
- Conversion: wq_rptr_bin is registered gray2bin(wq_rptr_gray), where bit i is the XOR of Gray bits ADRRSIZE..i.
- Fill: diff = (wptr_bin - wq_rptr_bin) mod 2**(ADRRSIZE+1). It is registered into wfill. wfull and walmost_full are registered from the same diff, so they are always consistent with wfill.
- Overflow: diff > DEPTH sets ovf_err. wfill still shows the raw diff and wfull=1.
- Gray check: a register holds the previous wq_rptr_gray. If popcount(previous XOR current) > 1, gray_err is set. A difference of 0 or 1 bit is legal.
- Sticky errors: each flag stays set until err_clr=1. If a set condition and err_clr occur in the same cycle, set wins and the flag stays 1.
- Writer contract: wfull lags wptr_bin by 1 cycle. The writer throttles on walmost_full, with AFULL_LVL chosen to cover its own write latency.

## Timing
- rptr_gray change to wq_rptr_gray: SYNC_STAGES cycles.
- To wq_rptr_bin: SYNC_STAGES+1 cycles.
- rptr_gray change to wfill, wfull and walmost_full: SYNC_STAGES+2 cycles.
- wptr_bin change to wfill and flags: 1 cycle.
- Bad Gray step to gray_err: SYNC_STAGES+1 cycles.
- Overflowing diff to ovf_err: 2 cycles after the diff appears in wq_rptr_bin/wptr_bin, and 1 cycle after wfill shows it.
- err_clr to flag low: 1 cycle, provided no new set condition occurs that cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package fifo_pkg holds:
  - functions gray2bin, bin2gray and popcount, parametrised on width;
  - constant MIN_SYNC_STAGES = 2.
- Sub-module sync_ff_chain is parameters WIDTH and STAGES, with wclk, wrst_n, d and q, and synchronous reset. The matching write-to-read synchroniser reuses it.
- Elaboration-time checks reject SYNC_STAGES < 2 or > 4, and AFULL_LVL outside 1..DEPTH.

## Test plan
All scenarios use ADRRSIZE=3, SYNC_STAGES=2, AFULL_LVL=6.
1. Reset: hold wrst_n=0 with rptr_gray=4'b0110 and wptr_bin=5 -> every output is 0. Release reset -> wq_rptr_gray=4'b0110 after 2 cycles.
2. Latency: step rptr_gray 0000->0001 at edge t -> wq_rptr_gray=0001 at t+2, wq_rptr_bin=1 at t+3, wfill reflects it at t+4.
3. Flags: rptr=0, wptr_bin=6 -> wfill=6, walmost_full=1, wfull=0. Set wptr_bin=8 -> wfill=8, wfull=1 one cycle later. Set wptr_bin=9 -> ovf_err=1 and stays 1 after wptr_bin returns to 8.
4. Wrap-around: rptr_bin=14 (gray 1001), wptr_bin=2 -> wfill=4, wfull=0, walmost_full=0.
5. Gray error: jump rptr_gray 0000->0011 -> gray_err=1 at t+3 and stays 1. Pulse err_clr -> 0 next cycle. Pulse err_clr during a new 2-bit jump -> gray_err stays 1.
6. Mid-operation reset: with wfull=1 and gray_err=1, drive wrst_n=0 for 1 cycle -> all outputs 0 the next cycle. Recovery then matches scenario 2 latencies.
